// File: rtl/random_arbiter_if.sv
// Requester-side bus of random_arbiter: requests, accepts, reseed and delivered word.
`timescale 1ns/1ps
interface random_arbiter_if #(
    parameter int unsigned BITS = 64,
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic            reseed;
    logic [NREQ-1:0] gnt;
    logic [BITS-1:0] data_out;
    logic            data_valid;
    logic            busy;

    modport master (
        output req, ack, reseed,
        input  gnt, data_out, data_valid, busy
    );

    modport slave (
        input  req, ack, reseed,
        output gnt, data_out, data_valid, busy
    );
endinterface

// File: rtl/random_arbiter.sv
// Round-robin arbiter handing out words from an external shift-register generator.
// Optional completed-transfer counter (word_count) enabled by RANDOM_ARBITER_STATS_EN.
`timescale 1ns/1ps
module random_arbiter #(
    parameter int unsigned BITS = 64,
    parameter int unsigned NREQ = 4,
    parameter int unsigned STEP = 4
) (
    input  logic            clk,
    input  logic            rs,
    random_arbiter_if.slave bus,
    output logic            rng_en,
    output logic            rng_rs,
    input  logic [BITS-1:0] rng_data
`ifdef RANDOM_ARBITER_STATS_EN
    ,
    output logic [31:0]     word_count
`endif
);
    localparam int unsigned   IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST      = IW'(NREQ - 1);
    localparam logic [3:0]    STEP_LAST = 4'(STEP - 1);

    typedef enum logic [1:0] {IDLE, RESEED, ADVANCE, DELIVER} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   own_q, own_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [IW-1:0]   pick, cand;
    logic            any_req;
    int unsigned     idx;
`ifdef RANDOM_ARBITER_STATS_EN
    logic [31:0]     wc_q, wc_d;
`endif

    // First requester found scanning upward from ptr, wrapping at NREQ.
    always_comb begin
        pick    = ptr_q;
        cand    = '0;
        idx     = 0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx  = (32'(ptr_q) + i) % NREQ;
            cand = IW'(idx);
            if (!any_req && bus.req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q | bus.reseed;
`ifdef RANDOM_ARBITER_STATS_EN
        wc_d    = wc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pend_q || bus.reseed) begin
                    state_d = RESEED;
                end else if (any_req) begin
                    state_d = ADVANCE;
                    own_d   = pick;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    cnt_d   = '0;
                end
            end
            RESEED: begin
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            ADVANCE: begin
                if (cnt_q == STEP_LAST) state_d = DELIVER;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            DELIVER: begin
                // Completion and abort both release the owner and move the pointer on.
                if (bus.ack[own_q] || !bus.req[own_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (own_q == LAST) ? '0 : own_q + 1'b1;
`ifdef RANDOM_ARBITER_STATS_EN
                    if (bus.ack[own_q]) wc_d = wc_q + 32'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
`ifdef RANDOM_ARBITER_STATS_EN
            wc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
`ifdef RANDOM_ARBITER_STATS_EN
            wc_q    <= wc_d;
`endif
        end
    end

    // Outputs follow the registered state; a low rs blanks them and restores the seed.
    always_comb begin
        bus.gnt        = gnt_q;
        bus.data_valid = (state_q == DELIVER);
        bus.data_out   = (state_q == DELIVER) ? rng_data : '0;
        bus.busy       = (state_q != IDLE);
        rng_en         = (state_q == ADVANCE);
        rng_rs         = (state_q == RESEED);
        if (!rs) begin
            bus.gnt        = '0;
            bus.data_valid = 1'b0;
            bus.data_out   = '0;
            bus.busy       = 1'b0;
            rng_en         = 1'b0;
            rng_rs         = 1'b1;
        end
    end

`ifdef RANDOM_ARBITER_STATS_EN
    assign word_count = wc_q;
`endif
endmodule

// File: tb/tb_random_arbiter.sv
// Directed bench for random_arbiter with a 64-bit shift-register generator alongside.
`timescale 1ns/1ps
module tb_random_arbiter;
    localparam int unsigned BITS = 64;
    localparam int unsigned NREQ = 4;
    localparam int unsigned STEP = 4;
    localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rs  = 1'b0;
    logic        rng_en, rng_rs;
    logic [63:0] rng_data;
`ifdef RANDOM_ARBITER_STATS_EN
    logic [31:0] word_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;
    int unsigned nshift   = 0;
    int unsigned last_dv  = 0;

    random_arbiter_if #(.BITS(BITS), .NREQ(NREQ)) bus ();

    random_arbiter #(.BITS(BITS), .NREQ(NREQ), .STEP(STEP)) dut (
        .clk        (clk),
        .rs         (rs),
        .bus        (bus),
        .rng_en     (rng_en),
        .rng_rs     (rng_rs),
        .rng_data   (rng_data)
`ifdef RANDOM_ARBITER_STATS_EN
        ,
        .word_count (word_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    function automatic logic [63:0] model(input int unsigned n);
        logic [63:0] s;
        s = SEED;
        for (int unsigned k = 0; k < n; k++) s = lfsr_next(s);
        return s;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rng_rs)      rng_data <= SEED;
        else if (rng_en) rng_data <= lfsr_next(rng_data);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        check({tag, " gnt"}, 64'(bus.gnt), 64'd0);
        check({tag, " dv"}, 64'(bus.data_valid), 64'd0);
        check({tag, " dout"}, bus.data_out, 64'd0);
        check({tag, " rng_en"}, 64'(rng_en), 64'd0);
    endtask

    task automatic do_reset;
        rs = 1'b0;
        #1;
        check_idle("rst");
        check("rst rng_rs", 64'(rng_rs), 64'd1);
        step;
        step;
        rs = 1'b1;
        #1;
        check_idle("post_rst");
        check("post_rst rng_rs", 64'(rng_rs), 64'd0);
`ifdef RANDOM_ARBITER_STATS_EN
        check("post_rst wc", 64'(word_count), 64'd0);
`endif
        nshift = 0;
    endtask

    // Called in IDLE with bus.req already presented; returns in IDLE after ack/abort.
    task automatic xfer(input string tag, input logic [3:0] exp_gnt, input bit rsd,
                        input bit abort, input logic [3:0] stray, input bit spacing);
        step;
        for (int unsigned k = 0; k < STEP; k++) begin
            check({tag, " adv gnt"}, 64'(bus.gnt), 64'(exp_gnt));
            check({tag, " adv rng_en"}, 64'(rng_en), 64'd1);
            check({tag, " adv dv"}, 64'(bus.data_valid), 64'd0);
            bus.reseed = rsd && (k == 1);
            step;
        end
        bus.reseed = 1'b0;
        nshift += STEP;
        check({tag, " dlv dv"}, 64'(bus.data_valid), 64'd1);
        check({tag, " dlv data"}, bus.data_out, model(nshift));
        check({tag, " dlv gnt"}, 64'(bus.gnt), 64'(exp_gnt));
        check({tag, " dlv rng_en"}, 64'(rng_en), 64'd0);
        if (spacing && last_dv != 0) check({tag, " dv spacing"}, 64'(cyc - last_dv), 64'd6);
        last_dv = cyc;
        if (stray != 4'd0) begin
            bus.ack = stray;
            step;
            check({tag, " stray dv"}, 64'(bus.data_valid), 64'd1);
            check({tag, " stray gnt"}, 64'(bus.gnt), 64'(exp_gnt));
        end
        if (abort) begin
            bus.req = '0;
            bus.ack = '0;
        end else begin
            bus.ack = exp_gnt;
        end
        step;
        bus.ack = '0;
        check_idle({tag, " end"});
    endtask

    initial begin
        bus.req    = '0;
        bus.ack    = '0;
        bus.reseed = 1'b0;

        do_reset;
        bus.req = 4'b0001;
        xfer("first", 4'b0001, 1'b0, 1'b0, 4'd0, 1'b0);
        bus.req = '0;

        do_reset;
        bus.req = 4'b1111;
        last_dv = 0;
        xfer("rr0", 4'b0001, 1'b0, 1'b0, 4'd0, 1'b1);
        xfer("rr1", 4'b0010, 1'b0, 1'b0, 4'd0, 1'b1);
        xfer("rr2", 4'b0100, 1'b0, 1'b0, 4'd0, 1'b1);
        xfer("rr3", 4'b1000, 1'b0, 1'b0, 4'd0, 1'b1);
        xfer("rr4", 4'b0001, 1'b0, 1'b0, 4'd0, 1'b1);
        bus.req = '0;

        bus.req = 4'b0010;
        xfer("abort", 4'b0010, 1'b0, 1'b1, 4'd0, 1'b0);
`ifdef RANDOM_ARBITER_STATS_EN
        check("abort wc", 64'(word_count), 64'd5);
`endif
        bus.req = 4'b0110;
        xfer("ptr_after_abort", 4'b0100, 1'b0, 1'b0, 4'b0010, 1'b0);
        bus.req = '0;
`ifdef RANDOM_ARBITER_STATS_EN
        check("wc6", 64'(word_count), 64'd6);
`endif

        bus.req = 4'b1000;
        xfer("reseed", 4'b1000, 1'b1, 1'b0, 4'd0, 1'b0);
        bus.req = 4'b0001;
        check("reseed idle rng_rs", 64'(rng_rs), 64'd0);
        step;
        check("reseed rng_rs", 64'(rng_rs), 64'd1);
        check("reseed busy", 64'(bus.busy), 64'd1);
        check("reseed gnt", 64'(bus.gnt), 64'd0);
        step;
        check("reseed done rng_rs", 64'(rng_rs), 64'd0);
        check("reseed done busy", 64'(bus.busy), 64'd0);
        nshift = 0;
        xfer("after_reseed", 4'b0001, 1'b0, 1'b0, 4'd0, 1'b0);
        bus.req = '0;

        bus.req = 4'b0010;
        step;
        step;
        step;
        check("mid_adv rng_en", 64'(rng_en), 64'd1);
        rs = 1'b0;
        #1;
        check_idle("mid_adv rst");
        check("mid_adv rst rng_rs", 64'(rng_rs), 64'd1);
        step;
        rs = 1'b1;
        #1;
        check_idle("mid_adv after");
        check("mid_adv after rng_rs", 64'(rng_rs), 64'd0);
`ifdef RANDOM_ARBITER_STATS_EN
        check("mid_adv wc", 64'(word_count), 64'd0);
`endif
        nshift = 0;
        xfer("post_rst_req", 4'b0010, 1'b0, 1'b0, 4'd0, 1'b0);
        bus.req = '0;

        rs = 1'b0;
        step;
        rs = 1'b1;
        bus.req = 4'b0110;
        step;
        check("ptr_zero gnt", 64'(bus.gnt), 64'(4'b0010));
        bus.req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/random_arbiter.md
RANDOM_ARBITER -- requirements
Module: random_arbiter

Interface
REQ-001 Parameter BITS, default 64, SHALL set the random word width.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter STEP, default 4, SHALL set the number of generator shifts per delivered word (1..15).
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rs  in  1  SHALL be a synchronous, active-low reset.
REQ-006 req  in  NREQ  SHALL carry per-requester word requests, level-held until ack or abort.
REQ-007 ack  in  NREQ  SHALL be the per-requester word-accept strobes.
REQ-008 reseed  in  1  SHALL be a one-cycle request to restore the generator seed.
REQ-009 gnt  out  NREQ  SHALL be the one-hot grant of the current owner, zero when idle.
REQ-010 data_out  out  BITS  SHALL be the delivered random word.
REQ-011 data_valid  out  1  SHALL qualify data_out.
REQ-012 rng_en  out  1  SHALL drive the generator shift enable.
REQ-013 rng_rs  out  1  SHALL drive the generator's active-high seed restore.
REQ-014 rng_data  in  BITS  SHALL be the generator's current word.
REQ-015 busy  out  1  SHALL be high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, RESEED, ADVANCE and DELIVER.
REQ-017 In IDLE, a pending reseed SHALL win over any req and move the FSM to RESEED.
REQ-018 RESEED SHALL last exactly one cycle with rng_rs=1, clear the pending flag and return to IDLE.
REQ-019 In IDLE with any req bit set and no pending reseed, the FSM SHALL grant round-robin starting at pointer ptr and enter ADVANCE.
REQ-020 gnt SHALL be registered and SHALL stay stable from the first ADVANCE cycle to the last DELIVER cycle.
REQ-021 ADVANCE SHALL last exactly STEP cycles, with rng_en=1 on each; rng_en SHALL be 0 in every other state.
REQ-022 DELIVER SHALL drive data_valid=1 and data_out=rng_data; data_out SHALL be 0 whenever data_valid=0.
REQ-023 Latency: req seen in IDLE on cycle 0 gives gnt on cycle 1, rng_en on cycles 1..STEP, and data_valid on cycle STEP+1.
REQ-024 In DELIVER, ack[owner]=1 SHALL complete the transfer: next state IDLE, ptr=owner+1 modulo NREQ.
REQ-025 ack bits of non-owners SHALL be ignored.
REQ-026 ack and req both 0 for the owner in DELIVER SHALL abort the transfer: next state IDLE, ptr advances as on completion, no word counted.
REQ-027 A reseed pulse in ADVANCE or DELIVER SHALL set a pending flag that is served on the next IDLE cycle; further pulses while pending SHALL merge.
REQ-028 Requests rising during ADVANCE or DELIVER SHALL wait for IDLE; there SHALL be no preemption.

Reset
REQ-029 rs=0 at a clock edge SHALL force IDLE, ptr=0 and pending flag=0.
REQ-030 rs=0 SHALL force gnt=0, data_valid=0, data_out=0, rng_en=0, busy=0.
REQ-031 rs=0 SHALL force rng_rs=1 on that cycle, so the generator seed is restored with any reset.
REQ-032 Reset mid-ADVANCE or mid-DELIVER SHALL drop the transfer with no completion.

Configuration
REQ-033 With macro RANDOM_ARBITER_STATS_EN defined, output word_count [31:0] SHALL count completed (acked) transfers, wrap at 2^32 and reset to 0.
REQ-034 Without RANDOM_ARBITER_STATS_EN, port word_count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Reset, then req=0001 held with ack on the first valid cycle -> gnt=0001 cycle 1, rng_en cycles 1-4, data_valid cycle 5, data_out equal to the model of the seed after 4 shifts.
REQ-036 req=1111 held, owner acks each word -> gnt sequence 0001,0010,0100,1000,0001 with data_valid spaced 6 cycles apart.
REQ-037 reseed pulsed on the 2nd ADVANCE cycle -> word delivered normally, then rng_rs=1 for exactly one cycle after return to IDLE, then the next grant.
REQ-038 Owner drops req in DELIVER without ack -> IDLE next cycle, ptr advanced, word_count unchanged.
REQ-039 rs=0 on the 3rd ADVANCE cycle -> all outputs 0 next cycle except rng_rs=1, ptr=0; req=0010 afterwards -> gnt=0010.
REQ-040 With STATS_EN, 5 completed plus 1 aborted transfer -> word_count=5; without it the build has no word_count port.
